// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_e;

  localparam logic [3:0] ROW_RESET          = 4'b1110;
  localparam logic [3:0] COL_IDLE           = 4'b1111;
  localparam int         DEBOUNCE_TICKS_DEF = 4;

  // Active-low one-hot pattern for a 2-bit index (row drive or expected col sense).
  function automatic logic [3:0] onehot_low(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/key_scan_ctrl_if.sv
// Keypad-side signals plus the decoded key report.
interface key_scan_ctrl_if;
  logic       tick;
  logic [3:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  modport master (
    output tick, col,
    input  row, key_valid, key_code, key_held
  );

  modport slave (
    input  tick, col,
    output row, key_valid, key_code, key_held
  );
endinterface

// File: rtl/key_scan_ctrl_col_encode.sv
// Column sense encoder: flags exactly one closed column and returns its index.
module col_encode (
  input  logic [3:0] col,
  output logic       single,
  output logic [1:0] col_idx
);

  always_comb begin
    single  = 1'b1;
    col_idx = 2'd0;
    case (col)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: single  = 1'b0;
    endcase
  end

endmodule

// File: rtl/key_scan_ctrl.sv
// 4x4 keypad scanner: rotates row drive, debounces press and release,
// and reports each accepted key once.
module key_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic           clk,
  input  logic           rst,
  key_scan_ctrl_if.slave kp
);

  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_TICKS);

  state_e     state_q, state_d;
  logic [1:0] row_idx_q, row_idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] lat_row_q, lat_row_d;
  logic [1:0] lat_col_q, lat_col_d;
  logic       accept;

  logic       key_valid_q;
  logic [3:0] key_code_q;

  logic       col_single;
  logic [1:0] col_idx;
  logic       col_match;
  logic       col_idle;
  logic [3:0] cnt_inc;

  col_encode u_col_encode (
    .col     (kp.col),
    .single  (col_single),
    .col_idx (col_idx)
  );

  assign col_match = (kp.col == onehot_low(lat_col_q));
  assign col_idle  = (kp.col == COL_IDLE);
  assign cnt_inc   = cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    lat_row_d = lat_row_q;
    lat_col_d = lat_col_q;
    accept    = 1'b0;
    if (kp.tick) begin
      case (state_q)
        ST_SCAN: begin
          // Ghosted or idle columns keep the scan moving.
          if (col_single) begin
            lat_row_d = row_idx_q;
            lat_col_d = col_idx;
            cnt_d     = 4'd0;
            state_d   = ST_DEBOUNCE;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (col_match) begin
            if (cnt_inc == DB_MAX) begin
              state_d = ST_HELD;
              cnt_d   = 4'd0;
              accept  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d   = ST_SCAN;
            cnt_d     = 4'd0;
            row_idx_d = row_idx_q + 2'd1;
          end
        end
        ST_HELD: begin
          if (col_idle) begin
            cnt_d   = 4'd0;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!col_idle) begin
            cnt_d   = 4'd0;
            state_d = ST_HELD;
          end else if (cnt_inc == DB_MAX) begin
            cnt_d     = 4'd0;
            state_d   = ST_SCAN;
            row_idx_d = row_idx_q + 2'd1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_SCAN;
      row_idx_q <= 2'd0;
      cnt_q     <= 4'd0;
      lat_row_q <= 2'd0;
      lat_col_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      cnt_q     <= cnt_d;
      lat_row_q <= lat_row_d;
      lat_col_q <= lat_col_d;
    end
  end

  // key_valid is a registered single-cycle pulse following the accept edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      key_valid_q <= accept;
      if (accept) key_code_q <= {lat_row_q, lat_col_q};
    end
  end

  assign kp.row       = onehot_low(row_idx_q);
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_held  = (state_q == ST_HELD) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed bench for key_scan_ctrl: vector table plus reset/hold sequences.
module tb_key_scan_ctrl;
  import keypad_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_scan_ctrl_if kp();

  key_scan_ctrl #(.DEBOUNCE_TICKS(4)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  typedef struct {
    logic [3:0] col;
    logic [3:0] row;
    logic       valid;
    logic       held;
    logic [3:0] code;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vq[$];

  function automatic vec_t mk(logic [3:0] c, logic [3:0] r, logic v, logic h, logic [3:0] k);
    vec_t t;
    t.col = c; t.row = r; t.valid = v; t.held = h; t.code = k;
    return t;
  endfunction

  task automatic check(input string name, input logic [3:0] r, input logic v,
                       input logic h, input logic [3:0] k);
    n_vec++;
    if (kp.row !== r || kp.key_valid !== v || kp.key_held !== h || kp.key_code !== k) begin
      n_bad++;
      $display("FAIL %s: got row=%b valid=%b held=%b code=%h, want row=%b valid=%b held=%b code=%h",
               name, kp.row, kp.key_valid, kp.key_held, kp.key_code, r, v, h, k);
    end
  endtask

  // One scan tick then one non-tick cycle with a noisy col that must be ignored.
  task automatic tick_chk(input string name, input logic [3:0] c, input logic [3:0] r,
                          input logic v, input logic h, input logic [3:0] k);
    kp.col  = c;
    kp.tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kp.tick = 1'b0;
    check(name, r, v, h, k);
    kp.col = 4'b1110;
    @(posedge clk);
    @(negedge clk);
    check({name, "_idle"}, r, 1'b0, h, k);
  endtask

  initial begin
    logic [3:0] wrap_rows [9];
    wrap_rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101,
                  4'b1011, 4'b0111, 4'b1110, 4'b1101};
    for (int i = 0; i < 9; i++) vq.push_back(mk(COL_IDLE, wrap_rows[i], 1'b0, 1'b0, 4'h0));
    vq.push_back(mk(4'b1100, 4'b1011, 1'b0, 1'b0, 4'h0));   // ghost: rotate
    vq.push_back(mk(4'b1101, 4'b1011, 1'b0, 1'b0, 4'h0));   // latch row2 col1
    for (int i = 0; i < 3; i++) vq.push_back(mk(4'b1101, 4'b1011, 1'b0, 1'b0, 4'h0));
    vq.push_back(mk(4'b1101, 4'b1011, 1'b1, 1'b1, 4'h9));   // accept
    vq.push_back(mk(4'b1101, 4'b1011, 1'b0, 1'b1, 4'h9));
    vq.push_back(mk(4'b1101, 4'b1011, 1'b0, 1'b1, 4'h9));
    vq.push_back(mk(4'b1110, 4'b1011, 1'b0, 1'b1, 4'h9));   // other col while held
    vq.push_back(mk(COL_IDLE, 4'b1011, 1'b0, 1'b1, 4'h9));  // enter release
    vq.push_back(mk(COL_IDLE, 4'b1011, 1'b0, 1'b1, 4'h9));
    vq.push_back(mk(4'b1101, 4'b1011, 1'b0, 1'b1, 4'h9));   // re-close: back to held
    vq.push_back(mk(COL_IDLE, 4'b1011, 1'b0, 1'b1, 4'h9));  // enter release again
    for (int i = 0; i < 3; i++) vq.push_back(mk(COL_IDLE, 4'b1011, 1'b0, 1'b1, 4'h9));
    vq.push_back(mk(COL_IDLE, 4'b0111, 1'b0, 1'b0, 4'h9));  // released, rotate
    vq.push_back(mk(4'b0111, 4'b0111, 1'b0, 1'b0, 4'h9));   // bounce: latch
    vq.push_back(mk(4'b0111, 4'b0111, 1'b0, 1'b0, 4'h9));
    vq.push_back(mk(COL_IDLE, 4'b1110, 1'b0, 1'b0, 4'h9));  // bounce drop, advance
    vq.push_back(mk(COL_IDLE, 4'b1101, 1'b0, 1'b0, 4'h9));

    kp.tick = 1'b0;
    kp.col  = COL_IDLE;
    rst     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset", ROW_RESET, 1'b0, 1'b0, 4'h0);
    rst = 1'b1;

    foreach (vq[i]) tick_chk($sformatf("vec%0d", i), vq[i].col, vq[i].row,
                             vq[i].valid, vq[i].held, vq[i].code);

    // Reset clears the reported code.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst_clear", ROW_RESET, 1'b0, 1'b0, 4'h0);

    // Reach debounce count 3 on row 2, then reset between clock edges.
    tick_chk("pre_a", COL_IDLE, 4'b1101, 1'b0, 1'b0, 4'h0);
    tick_chk("pre_b", COL_IDLE, 4'b1011, 1'b0, 1'b0, 4'h0);
    tick_chk("db_latch", 4'b0111, 4'b1011, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) tick_chk("db_cnt", 4'b0111, 4'b1011, 1'b0, 1'b0, 4'h0);
    #2 rst = 1'b0;
    #1 check("rst_async_db", ROW_RESET, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    check("rst_hold_db", ROW_RESET, 1'b0, 1'b0, 4'h0);
    rst = 1'b1;

    // First tick after reset samples row 0.
    tick_chk("r0_latch", 4'b1110, ROW_RESET, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) tick_chk("r0_cnt", 4'b1110, ROW_RESET, 1'b0, 1'b0, 4'h0);
    tick_chk("r0_accept", 4'b1110, ROW_RESET, 1'b1, 1'b1, 4'h0);

    // Long hold: no auto-repeat, row frozen.
    for (int i = 0; i < 20; i++) tick_chk("hold20", 4'b1110, ROW_RESET, 1'b0, 1'b1, 4'h0);

    // Reset while held drops the key without a pulse.
    #2 rst = 1'b0;
    #1 check("rst_async_held", ROW_RESET, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    tick_chk("post_rst", COL_IDLE, 4'b1101, 1'b0, 1'b0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/key_scan_ctrl.md
KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_TICKS, default 4, number of consecutive stable scan ticks required to accept a press or a release (range 2..15).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 tick  input  1  one-clk-wide scan strobe from the frequency divider; the block samples and advances only on cycles with tick=1.
REQ-005 col  input  4  keypad column sense, active-low; bit c=0 means a key in the driven row and column c is closed.
REQ-006 row  output  4  keypad row drive, active-low one-hot (exactly one bit 0 at all times).
REQ-007 key_valid  output  1  one-clk pulse: a debounced new press is accepted.
REQ-008 key_code  output  4  code of the last accepted key = row_idx*4 + col_idx; held between pulses.
REQ-009 key_held  output  1  high while an accepted key remains pressed (HELD and RELEASE states).

Function
REQ-010 The FSM SHALL have the states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-011 SCAN: on each tick with col=4'b1111 or with more than one col bit low, row SHALL rotate 1110->1101->1011->0111->1110 (row_idx 0..3, wrapping).
REQ-012 SCAN: on a tick with exactly one col bit low, the block SHALL latch row_idx and col_idx, freeze row, clear the counter and enter DEBOUNCE.
REQ-013 DEBOUNCE: on each tick where col equals the latched pattern, the counter SHALL increment; on the tick it reaches DEBOUNCE_TICKS, state SHALL go to HELD.
REQ-014 DEBOUNCE: on a tick where col differs from the latched pattern, state SHALL return to SCAN and row SHALL advance to the next row on that same tick; key_valid SHALL NOT fire.
REQ-015 On the DEBOUNCE->HELD transition, key_code SHALL load the latched code and key_valid SHALL be 1 in the following clk cycle only (registered, exactly one cycle per accepted press).
REQ-016 HELD: row SHALL stay frozen and no further key_valid SHALL be produced (no auto-repeat); a tick with col=4'b1111 SHALL clear the counter and enter RELEASE.
REQ-017 RELEASE: each tick with col=4'b1111 SHALL increment the counter; at DEBOUNCE_TICKS, state SHALL go to SCAN with row advanced to the next row; any tick with col!=4'b1111 SHALL clear the counter and return to HELD.
REQ-018 A second key closed in another row while HELD SHALL be ignored, since only the frozen row is driven.
REQ-019 Cycles with tick=0 SHALL leave state, counter, row and key_code unchanged; col is not sampled.
REQ-020 The counter width SHALL be 4 bits and SHALL never wrap, because it saturates at DEBOUNCE_TICKS by transition.

Reset
REQ-021 When rst=0, the block SHALL asynchronously force: state=SCAN, row=4'b1110, counter=0, key_valid=0, key_code=4'h0, key_held=0, latched row/col=0.
REQ-022 Reset asserted mid-DEBOUNCE or mid-HELD SHALL drop any pending press without emitting key_valid.
REQ-023 After rst deasserts, the first tick SHALL sample row 0.

Structure
REQ-024 A shared package keypad_pkg SHALL hold the state enumeration, ROW_RESET=4'b1110, COL_IDLE=4'b1111 and the DEBOUNCE_TICKS default.
REQ-025 One combinational sub-module col_encode SHALL map col to {single, col_idx[1:0]}, where single=1 if and only if exactly one bit is low.
REQ-026 The total RTL SHALL be approximately 150-250 lines, with one registered FSM process and one output register process.

Verification
REQ-027 Clean press: hold col=1101 (col_idx 1) while row=1011 (row_idx 2) for 4 ticks -> exactly one key_valid pulse, key_code=4'h9, key_held=1, row frozen at 1011.
REQ-028 Bounce: col=0111 for 2 ticks, then 1111 for 1 tick -> no key_valid, state SCAN, row advances to the next row.
REQ-029 Hold and release: press accepted, held 20 ticks, released with one 1-tick re-close inside the release window, then 4 stable idle ticks -> exactly one key_valid, key_held drops only after the final 4 idle ticks, rotation resumes.
REQ-030 Ghost: col=1100 on any tick in SCAN -> no latch, rotation continues unchanged.
REQ-031 Reset mid-operation: rst=0 during DEBOUNCE at count 3 -> row=1110 and key_valid=0 immediately (no clock needed); after release of reset, a 4-tick press on row 0 col 0 -> key_code=4'h0.
REQ-032 Wrap: idle for 9 ticks from reset -> row sequence 1101,1011,0111,1110,1101,1011,0111,1110,1101.
